// File: rtl/hazard_scoreboard_unit_pkg.sv
// Common types for the hazard/forwarding scoreboard unit.
//  FSEL_W          select width for the default two forwarding stages
//  stall_cause_t   reason reported alongside stall
//  mc_state_t      multicycle-unit tracking states
//  mux_control_type  legacy two-stage forwarding mux encoding
package hazard_scoreboard_unit_pkg;

  localparam int DEF_NUM_FWD = 2;
  localparam int FSEL_W      = $clog2(DEF_NUM_FWD + 1);

  typedef enum logic [1:0] {
    STALL_NONE      = 2'd0,
    STALL_LOAD_USE  = 2'd1,
    STALL_MC_RAW    = 2'd2,
    STALL_MC_STRUCT = 2'd3
  } stall_cause_t;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DRAIN = 2'd2
  } mc_state_t;

  // Kept for older two-stage forwarding users: matches fwd_sel of the default config.
  typedef enum logic [1:0] {
    MUX_REGFILE = 2'd0,
    MUX_EX_MEM  = 2'd1,
    MUX_MEM_WB  = 2'd2
  } mux_control_type;

endpackage

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Forwarding priority encoder for one source operand.
//  rs            source register address in ID/EX
//  fwd_rd        destination of each forwarding stage (stage 0 = youngest)
//  fwd_regwrite  write enable of each forwarding stage
//  sel           0 = register file, k = forward from stage k-1
module hazard_scoreboard_unit_fwd_select
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_FWD    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_ADDR_W-1:0]         rs,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_regwrite,
  output logic [SEL_W-1:0]              sel
);

  // Scan oldest to youngest so the youngest matching stage overwrites last; x0 never matches.
  always_comb begin
    sel = {SEL_W{1'b0}};
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      sel = (fwd_regwrite[k] &&
             (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] != {REG_ADDR_W{1'b0}}) &&
             (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) ? SEL_W'(k + 1) : sel;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding select, load-use detection and multicycle-unit busy scoreboard.
//  clk, reset_n              clock, async active-low reset
//  ex_rs/fwd_rd/fwd_regwrite forwarding lookup inputs  -> fwd_sel
//  id_rs/id_rs_used          decode-stage operands     -> stall, stall_cause
//  id_ex_memread/id_ex_rd    load in ID/EX
//  mc_issue/mc_rd/mc_done    multicycle unit handshake -> busy_vec, mc_squash
//  flush                     pipeline flush
//  stall_cycles              saturating count of stalled cycles
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_READ    = 2,
  parameter int NUM_FWD     = 2,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16,
  localparam int SEL_W      = $clog2(NUM_FWD + 1),
  localparam int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_READ*REG_ADDR_W-1:0] ex_rs,
  input  logic [NUM_FWD*REG_ADDR_W-1:0]  fwd_rd,
  input  logic [NUM_FWD-1:0]             fwd_regwrite,
  input  logic [NUM_READ*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_READ-1:0]            id_rs_used,
  input  logic                           id_ex_memread,
  input  logic [REG_ADDR_W-1:0]          id_ex_rd,
  input  logic                           mc_issue,
  input  logic [REG_ADDR_W-1:0]          mc_rd,
  input  logic                           mc_done,
  input  logic                           flush,
  output logic [NUM_READ*SEL_W-1:0]      fwd_sel,
  output logic                           stall,
  output logic [1:0]                     stall_cause,
  output logic                           mc_squash,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic [STALL_CNT_W-1:0]         stall_cycles
);

  mc_state_t             state;
  logic [REG_ADDR_W-1:0] mc_rd_q;
  logic                  load_use;
  logic                  mc_raw;
  logic                  mc_struct;
  logic                  issue_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_fwd
      hazard_scoreboard_unit_fwd_select #(
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W),
        .SEL_W      (SEL_W)
      ) u_fwd_select (
        .rs           (ex_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .sel          (fwd_sel[gi*SEL_W +: SEL_W])
      );
    end
  endgenerate

  // Hazard sources; busy_vec bit 0 is never set, so x0 reads never hit the scoreboard.
  always_comb begin
    load_use = 1'b0;
    mc_raw   = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      load_use = load_use | (id_ex_memread && (id_ex_rd != {REG_ADDR_W{1'b0}}) &&
                             id_rs_used[i] && (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd));
      mc_raw   = mc_raw | (id_rs_used[i] && busy_vec[id_rs[i*REG_ADDR_W +: REG_ADDR_W]]);
    end
    // WAW against an outstanding multicycle destination.
    mc_raw    = mc_raw | (mc_issue && busy_vec[mc_rd]);
    // The unit can only take a new op when idle or when the current one retires this cycle.
    mc_struct = mc_issue && (state != MC_IDLE) && !((state == MC_BUSY) && mc_done);
  end

  // Stall and prioritised cause.
  always_comb begin
    stall = load_use | mc_raw | mc_struct;
    if (load_use) begin
      stall_cause = STALL_LOAD_USE;
    end else if (mc_raw) begin
      stall_cause = STALL_MC_RAW;
    end else if (mc_struct) begin
      stall_cause = STALL_MC_STRUCT;
    end else begin
      stall_cause = STALL_NONE;
    end
  end

  assign issue_ok  = mc_issue && !stall;
  assign mc_squash = (state == MC_DRAIN) && mc_done;

  // Multicycle FSM and busy scoreboard; the set is written after the clear so a same-register
  // retire+issue leaves the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= MC_IDLE;
      mc_rd_q  <= {REG_ADDR_W{1'b0}};
      busy_vec <= {NUM_REGS{1'b0}};
    end else begin
      case (state)
        MC_IDLE: begin
          if (issue_ok) begin
            state   <= MC_BUSY;
            mc_rd_q <= mc_rd;
          end else begin
            state <= MC_IDLE;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            busy_vec[mc_rd_q] <= 1'b0;
            if (issue_ok) begin
              state   <= MC_BUSY;
              mc_rd_q <= mc_rd;
            end else begin
              state <= MC_IDLE;
            end
          end else if (flush) begin
            // Result still in flight belongs to a squashed path; wait for it and discard.
            state <= MC_DRAIN;
          end else begin
            state <= MC_BUSY;
          end
        end
        MC_DRAIN: begin
          if (mc_done) begin
            busy_vec[mc_rd_q] <= 1'b0;
            state             <= MC_IDLE;
          end else begin
            state <= MC_DRAIN;
          end
        end
        default: begin
          state <= MC_IDLE;
        end
      endcase
      if (issue_ok && (mc_rd != {REG_ADDR_W{1'b0}})) begin
        busy_vec[mc_rd] <= 1'b1;
      end else begin
        busy_vec[0] <= 1'b0;
      end
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= {STALL_CNT_W{1'b0}};
    end else if (stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: directed stimulus pushes expected values
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  ex_rs, fwd_rd, id_rs;
  logic [1:0]  fwd_regwrite, id_rs_used;
  logic        id_ex_memread, mc_issue, mc_done, flush;
  logic [4:0]  id_ex_rd, mc_rd;
  logic [3:0]  fwd_sel;
  logic        stall, mc_squash;
  logic [1:0]  stall_cause;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;

  localparam int F_FWD0 = 0, F_FWD1 = 1, F_STALL = 2, F_CAUSE = 3,
                 F_SQUASH = 4, F_BUSY = 5, F_CYC = 6;

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [31:0] act;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard_unit dut (
    .clk(clk), .reset_n(reset_n), .ex_rs(ex_rs), .fwd_rd(fwd_rd),
    .fwd_regwrite(fwd_regwrite), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .mc_issue(mc_issue),
    .mc_rd(mc_rd), .mc_done(mc_done), .flush(flush), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cause(stall_cause), .mc_squash(mc_squash),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int fld);
    case (fld)
      F_FWD0:   return {30'd0, fwd_sel[1:0]};
      F_FWD1:   return {30'd0, fwd_sel[3:2]};
      F_STALL:  return {31'd0, stall};
      F_CAUSE:  return {30'd0, stall_cause};
      F_SQUASH: return {31'd0, mc_squash};
      F_BUSY:   return busy_vec;
      F_CYC:    return {16'd0, stall_cycles};
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      act = actual(cur.fld);
      n_cmp++;
      if (act !== cur.exp) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", cur.name, cur.cyc, act, cur.exp);
      end
    end
  end

  task automatic chk(input string name, input int fld, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.fld  = fld;
    e.exp  = v;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_rs = 10'd0; fwd_rd = 10'd0; fwd_regwrite = 2'b00;
    id_rs = 10'd0; id_rs_used = 2'b00; id_ex_memread = 1'b0; id_ex_rd = 5'd0;
    mc_issue = 1'b0; mc_rd = 5'd0; mc_done = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    step();
    chk("rst_stall", F_STALL, 32'd0);
    chk("rst_busy", F_BUSY, 32'd0);
    chk("rst_cycles", F_CYC, 32'd0);
    chk("rst_squash", F_SQUASH, 32'd0);
    chk("rst_fwd0", F_FWD0, 32'd0);
    step(); reset_n = 1'b1;

    // Forwarding
    ex_rs = {5'd0, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11;
    chk("fwd_youngest", F_FWD0, 32'd1);
    chk("fwd_rs1_x0", F_FWD1, 32'd0);
    step(); fwd_regwrite = 2'b10;
    chk("fwd_oldest", F_FWD0, 32'd2);
    step(); ex_rs = {5'd3, 5'd0}; fwd_rd = {5'd3, 5'd0}; fwd_regwrite = 2'b11;
    chk("fwd_x0_never", F_FWD0, 32'd0);
    chk("fwd_rs1_stage1", F_FWD1, 32'd2);
    step(); ex_rs = {5'd3, 5'd3}; fwd_rd = {5'd3, 5'd3};
    chk("fwd_both0", F_FWD0, 32'd1);
    chk("fwd_both1", F_FWD1, 32'd1);

    // Load-use
    step(); idle_in(); id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    chk("lu_stall", F_STALL, 32'd1);
    chk("lu_cause", F_CAUSE, 32'd1);
    step(); id_rs_used = 2'b00;
    chk("lu_unused", F_STALL, 32'd0);
    chk("lu_cause_none", F_CAUSE, 32'd0);
    chk("lu_cycles", F_CYC, 32'd1);
    step(); id_ex_rd = 5'd0; id_rs = 10'd0; id_rs_used = 2'b01;
    chk("lu_x0", F_STALL, 32'd0);

    // Multicycle RAW / structural
    step(); idle_in(); mc_issue = 1'b1; mc_rd = 5'd9;
    chk("mc_issue_ok", F_STALL, 32'd0);
    step(); mc_rd = 5'd10; id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
    chk("raw_stall", F_STALL, 32'd1);
    chk("raw_cause", F_CAUSE, 32'd2);
    chk("raw_busy9", F_BUSY, 32'h0000_0200);
    step(); id_rs_used = 2'b00;
    chk("struct_cause", F_CAUSE, 32'd3);
    step(); mc_issue = 1'b0; mc_done = 1'b1;
    chk("done_nostall", F_STALL, 32'd0);
    step(); mc_done = 1'b0; id_rs_used = 2'b10;
    chk("raw_cleared", F_STALL, 32'd0);
    chk("busy_cleared", F_BUSY, 32'd0);
    chk("raw_cycles", F_CYC, 32'd3);

    // Flush -> drain -> squash
    step(); idle_in(); mc_issue = 1'b1; mc_rd = 5'd9;
    chk("dr_issue", F_STALL, 32'd0);
    step(); mc_issue = 1'b0; flush = 1'b1;
    chk("dr_flush_sq", F_SQUASH, 32'd0);
    step();
    chk("dr_busy", F_BUSY, 32'h0000_0200);
    chk("dr_wait_sq", F_SQUASH, 32'd0);
    step(); flush = 1'b0; mc_issue = 1'b1; mc_rd = 5'd3;
    chk("dr_struct", F_CAUSE, 32'd3);
    step(); mc_issue = 1'b0; mc_done = 1'b1;
    chk("dr_squash", F_SQUASH, 32'd1);
    chk("dr_done_stall", F_STALL, 32'd0);
    step(); mc_done = 1'b0;
    chk("dr_after_sq", F_SQUASH, 32'd0);
    chk("dr_after_busy", F_BUSY, 32'd0);
    chk("dr_cycles", F_CYC, 32'd4);

    // Back-to-back retire + issue, cause priority
    step(); mc_issue = 1'b1; mc_rd = 5'd9;
    step(); mc_done = 1'b1; mc_rd = 5'd4;
    chk("b2b_nostall", F_STALL, 32'd0);
    chk("b2b_nosquash", F_SQUASH, 32'd0);
    step(); mc_done = 1'b0; mc_rd = 5'd6; id_ex_memread = 1'b1; id_ex_rd = 5'd4;
    id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01;
    chk("b2b_busy4", F_BUSY, 32'h0000_0010);
    chk("prio_lu", F_CAUSE, 32'd1);
    step(); idle_in(); mc_done = 1'b1;
    chk("b2b_done", F_STALL, 32'd0);
    chk("b2b_cycles", F_CYC, 32'd5);
    step(); mc_done = 1'b0;
    chk("b2b_clear", F_BUSY, 32'd0);

    // Async reset mid-operation with 12 stalled cycles
    step(); mc_issue = 1'b1; mc_rd = 5'd9;
    for (int i = 0; i < 7; i++) begin
      step(); idle_in(); id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      chk("hold_raw", F_CAUSE, 32'd2);
    end
    step(); idle_in();
    chk("pre_rst_cycles", F_CYC, 32'd12);
    chk("pre_rst_busy", F_BUSY, 32'h0000_0200);
    step(); reset_n = 1'b0;
    chk("arst_busy", F_BUSY, 32'd0);
    chk("arst_cycles", F_CYC, 32'd0);
    chk("arst_stall", F_STALL, 32'd0);
    step(); id_ex_memread = 1'b1; id_ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    chk("rst_lu_stall", F_STALL, 32'd1);
    chk("rst_lu_cycles", F_CYC, 32'd0);
    step(); reset_n = 1'b1; idle_in(); mc_issue = 1'b1; mc_rd = 5'd2;
    chk("post_rst_idle", F_STALL, 32'd0);
    step(); idle_in();
    chk("post_rst_busy", F_BUSY, 32'h0000_0004);

    // Flush with done in the same cycle commits the result
    flush = 1'b1; mc_done = 1'b1;
    chk("flush_done_sq", F_SQUASH, 32'd0);
    step(); idle_in(); mc_issue = 1'b1; mc_rd = 5'd5;
    chk("flush_done_busy", F_BUSY, 32'd0);
    chk("flush_done_idle", F_STALL, 32'd0);
    step(); idle_in();
    chk("reissue_busy", F_BUSY, 32'h0000_0020);

    step(); step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
